// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2
  } rx_state_e;

  // cfg_data_bits encodes the character length as value + DATA_BITS_OFS
  localparam int DATA_BITS_OFS = 5;

  typedef struct packed {
    logic       frm_err;
    logic       par_err;
    logic [7:0] data;
  } rx_entry_t;

  localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received characters; head data reads as zero while empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_wr, do_rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign count = cnt;

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchroniser, frame FSM with half/full bit counter, and RX FIFO.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic                          cfg_en,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_stop_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_even_par,
  input  logic [DIV_W-1:0]              cfg_divisor,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_par_err,
  output logic                          rx_frm_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_cnt,
  output logic                          rx_overrun,
  output logic                          rx_busy
);

  // Two extra bits so a full bit period fits even at the largest divisor
  localparam int CW = DIV_W + 2;

  rx_state_e state, nstate;

  logic          rxd_meta, rxs, rxs_q, fall;
  logic [CW-1:0] cnt, lat_hb, bp;
  logic [2:0]    lat_last, bit_idx;
  logic          lat_stop2, lat_par_en, lat_even;
  logic [7:0]    data;
  logic          par_err, frm_err;
  logic          expire, push, fifo_full, fifo_empty;
  rx_entry_t     push_entry, head;
  logic [3:0]    nbits_m1;

  always_ff @(posedge mclk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
      rxs_q    <= rxs;
    end
  end

  assign fall     = rxs_q & ~rxs;
  assign expire   = (cnt == CW'(1));
  assign bp       = lat_hb << 1;
  assign nbits_m1 = {2'b00, cfg_data_bits} + 4'(DATA_BITS_OFS - 1);

  always_ff @(posedge mclk) begin
    if (reset) state <= RX_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (!cfg_en) begin
      nstate = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE:   if (fall) nstate = RX_START;
        RX_START:  if (expire) nstate = rxs ? RX_IDLE : RX_DATA;
        RX_DATA:   if (expire && bit_idx == lat_last)
                     nstate = lat_par_en ? RX_PARITY : RX_STOP1;
        RX_PARITY: if (expire) nstate = RX_STOP1;
        RX_STOP1:  if (expire) nstate = lat_stop2 ? RX_STOP2 : RX_IDLE;
        RX_STOP2:  if (expire) nstate = RX_IDLE;
        default:   nstate = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy            = (state != RX_IDLE);
    push               = cfg_en && expire &&
                         ((state == RX_STOP1 && !lat_stop2) || state == RX_STOP2);
    push_entry.frm_err = frm_err | ~rxs;
    push_entry.par_err = par_err;
    push_entry.data    = data;
  end

  // Frame datapath: cfg snapshot at the start edge, then one sample per counter expiry
  always_ff @(posedge mclk) begin
    if (reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= '0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      lat_hb     <= '0;
      lat_last   <= '0;
      lat_stop2  <= 1'b0;
      lat_par_en <= 1'b0;
      lat_even   <= 1'b0;
    end else if (state == RX_IDLE) begin
      if (cfg_en && fall) begin
        cnt        <= {2'b00, cfg_divisor} + CW'(1);
        lat_hb     <= {2'b00, cfg_divisor} + CW'(1);
        lat_last   <= nbits_m1[2:0];
        lat_stop2  <= cfg_stop_bits;
        lat_par_en <= cfg_parity_en;
        lat_even   <= cfg_even_par;
        bit_idx    <= '0;
        data       <= '0;
        par_err    <= 1'b0;
        frm_err    <= 1'b0;
      end
    end else if (expire) begin
      cnt <= bp;
      case (state)
        RX_DATA: begin
          data[bit_idx] <= rxs;
          bit_idx       <= bit_idx + 3'd1;
        end
        RX_PARITY: par_err <= (rxs != (lat_even ? ^data : ~^data));
        RX_STOP1,
        RX_STOP2:  frm_err <= frm_err | ~rxs;
        default:   ;
      endcase
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) rx_overrun <= 1'b0;
    else       rx_overrun <= push && fifo_full && !rx_ready;
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RX_ENTRY_W)
  ) u_fifo (
    .clk     (mclk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (rx_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rx_fifo_cnt)
  );

  assign rx_valid   = ~fifo_empty;
  assign rx_data    = head.data;
  assign rx_par_err = head.par_err;
  assign rx_frm_err = head.frm_err;

endmodule
